// File: rtl/genesis_pad_responder.sv
// Pad-side responder for the Genesis multiplexed controller port: drives the six
// active-low pins from a pressed-button vector, following the 3/6-button select protocol.
module genesis_pad_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 75000,
  parameter bit          SIX_BUTTON     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selectSignal,
  input  logic [10:0] buttons_in,
  output logic        up_z,
  output logic        down_y,
  output logic        left_x,
  output logic        right,
  output logic        a_b,
  output logic        start_c
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_sel_d;
  logic [TW-1:0] r_to_cnt;
  phase_t        r_phase;
  phase_t        w_phase_next;
  logic [5:0]    r_pins;
  logic [5:0]    w_pins;
  logic [10:0]   w_n;
  logic          w_rise;
  logic          w_fall;
  logic          w_edge;
  logic          w_timeout;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sel_d <= 1'b1;
    end else begin
      r_sync1 <= selectSignal;
      r_sync2 <= r_sync1;
      r_sel_d <= r_sync2;
    end
  end

  assign w_rise    = r_sync2 & ~r_sel_d;
  assign w_fall    = ~r_sync2 & r_sel_d;
  assign w_edge    = w_rise | w_fall;
  assign w_timeout = (r_to_cnt == TO_LAST);

  // Idle counter: cleared by any select edge, saturates at the timeout value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_edge) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= PH0;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Phase advances on each synced rise; an edge in the same cycle beats the timeout
  always_comb begin
    w_phase_next = r_phase;
    if (!SIX_BUTTON) begin
      w_phase_next = PH0;
    end else if (w_rise) begin
      case (r_phase)
        PH0:     w_phase_next = PH1;
        PH1:     w_phase_next = PH2;
        PH2:     w_phase_next = PH3;
        default: w_phase_next = PH0;
      endcase
    end else if (!w_fall && w_timeout) begin
      w_phase_next = PH0;
    end
  end

  assign w_n = ~buttons_in;

  // Pin map {up_z,down_y,left_x,right,a_b,start_c}, using the phase that takes effect this edge
  always_comb begin
    w_pins = 6'b111111;
    if (r_sync2) begin
      if (w_phase_next == PH3) begin
        w_pins = {w_n[10], w_n[9], w_n[8], 1'b1, 1'b1, 1'b1};
      end else begin
        w_pins = {w_n[0], w_n[1], w_n[2], w_n[3], w_n[5], w_n[6]};
      end
    end else begin
      case (w_phase_next)
        PH3:     w_pins = {4'b1111, w_n[4], w_n[7]};
        PH2:     w_pins = {4'b0000, w_n[4], w_n[7]};
        default: w_pins = {w_n[0], w_n[1], 2'b00, w_n[4], w_n[7]};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pins <= 6'b111111;
    end else begin
      r_pins <= w_pins;
    end
  end

  assign up_z    = r_pins[5];
  assign down_y  = r_pins[4];
  assign left_x  = r_pins[3];
  assign right   = r_pins[2];
  assign a_b     = r_pins[1];
  assign start_c = r_pins[0];

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Directed bench for genesis_pad_responder: default, short-timeout and 3-button-only
// instances share one stimulus stream; pins compared as {up_z,down_y,left_x,right,a_b,start_c}.
module tb_genesis_pad_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [10:0] btn;
  wire  [5:0]  p_main;
  wire  [5:0]  p_to;
  wire  [5:0]  p_3b;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  genesis_pad_responder dut_main (
    .clk(clk), .reset(reset), .selectSignal(sel), .buttons_in(btn),
    .up_z(p_main[5]), .down_y(p_main[4]), .left_x(p_main[3]),
    .right(p_main[2]), .a_b(p_main[1]), .start_c(p_main[0])
  );

  genesis_pad_responder #(.TIMEOUT_CYCLES(100), .SIX_BUTTON(1'b1)) dut_to (
    .clk(clk), .reset(reset), .selectSignal(sel), .buttons_in(btn),
    .up_z(p_to[5]), .down_y(p_to[4]), .left_x(p_to[3]),
    .right(p_to[2]), .a_b(p_to[1]), .start_c(p_to[0])
  );

  genesis_pad_responder #(.TIMEOUT_CYCLES(75000), .SIX_BUTTON(1'b0)) dut_3b (
    .clk(clk), .reset(reset), .selectSignal(sel), .buttons_in(btn),
    .up_z(p_3b[5]), .down_y(p_3b[4]), .left_x(p_3b[3]),
    .right(p_3b[2]), .a_b(p_3b[1]), .start_c(p_3b[0])
  );

  task automatic check_pins(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Hold select at lvl for n clocks; returns #1 after the last rising edge
  task automatic drive_sel(input logic lvl, input int n);
    sel = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse reset with select high, then release into an idle-high line
  task automatic do_reset();
    reset = 1'b1;
    sel   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_pins("rst_hold", p_main, 6'b111111);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [5:0] lo_exp [4] = '{6'b110011, 6'b110011, 6'b000011, 6'b111111};
  logic [5:0] hi_exp [4] = '{6'b111111, 6'b111111, 6'b000111, 6'b111111};

  initial begin
    // Reset with select low and everything pressed
    reset = 1'b1;
    sel   = 1'b0;
    btn   = 11'h7FF;
    repeat (3) @(posedge clk);
    #1;
    check_pins("rst_main", p_main, 6'b111111);
    check_pins("rst_to",   p_to,   6'b111111);
    check_pins("rst_3b",   p_3b,   6'b111111);
    reset = 1'b0;
    drive_sel(1'b1, 3);
    check_pins("all_pressed_hi", p_main, 6'b000000);

    // Up only, pins follow buttons with one cycle of latency while select is held
    btn = 11'h001;
    @(posedge clk);
    #1;
    check_pins("up_hi", p_main, 6'b011111);
    drive_sel(1'b0, 20);
    check_pins("up_lo", p_main, 6'b010011);
    drive_sel(1'b1, 20);
    check_pins("up_hi_c1", p_main, 6'b011111);

    // X/Y/Z through a full phase cycle and wrap
    do_reset();
    btn = 11'h700;
    for (int i = 0; i < 4; i++) begin
      drive_sel(1'b0, 20);
      check_pins($sformatf("xyz_lo%0d", i), p_main, lo_exp[i]);
      drive_sel(1'b1, 20);
      check_pins($sformatf("xyz_hi%0d", i), p_main, hi_exp[i]);
    end
    drive_sel(1'b0, 20);
    check_pins("xyz_lo_wrap", p_main, 6'b110011);

    // Idle timeout after two pulses: short-timeout pad restarts at phase 0
    do_reset();
    btn = 11'h700;
    for (int i = 0; i < 2; i++) begin
      drive_sel(1'b0, 20);
      drive_sel(1'b1, 20);
    end
    drive_sel(1'b1, 110);
    check_pins("idle_hi_main", p_main, 6'b111111);
    drive_sel(1'b0, 20);
    check_pins("to_lo_main", p_main, 6'b000011);
    check_pins("to_lo_short", p_to, 6'b110011);
    drive_sel(1'b1, 20);
    check_pins("to_hi_main", p_main, 6'b000111);
    check_pins("to_hi_short", p_to, 6'b111111);

    // Timeout while parked in the X/Y/Z high phase
    do_reset();
    btn = 11'h700;
    for (int i = 0; i < 3; i++) begin
      drive_sel(1'b0, 20);
      drive_sel(1'b1, 20);
    end
    check_pins("c3_hi_short", p_to, 6'b000111);
    drive_sel(1'b1, 110);
    check_pins("c3_idle_short", p_to, 6'b111111);
    check_pins("c3_idle_main", p_main, 6'b000111);

    // 3-button pad never shows Z; 6-button pad does
    do_reset();
    btn = 11'h400;
    for (int i = 0; i < 5; i++) begin
      drive_sel(1'b0, 4);
      check_pins($sformatf("3b_lo%0d", i), p_3b, 6'b110011);
      drive_sel(1'b1, 4);
      check_pins($sformatf("3b_hi%0d", i), p_3b, 6'b111111);
      if (i == 2) check_pins("6b_z_hi", p_main, 6'b011111);
    end

    // Reset mid-sequence, first low phase afterwards uses phase 0
    do_reset();
    btn = 11'h001;
    for (int i = 0; i < 2; i++) begin
      drive_sel(1'b0, 20);
      drive_sel(1'b1, 20);
    end
    drive_sel(1'b0, 20);
    check_pins("mid_lo_id", p_main, 6'b000011);
    reset = 1'b1;
    #1;
    check_pins("mid_rst_async", p_main, 6'b111111);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_pins("post_rst_lo", p_main, 6'b010011);
    drive_sel(1'b1, 20);
    check_pins("post_rst_hi", p_main, 6'b011111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
